decoder_scan_seq: RTL and testbench
===================================

# decoder_scan_seq

Channel-scan sequencer that drives the select/enable inputs of the 4-to-16 decoder: `sel` connects to the decoder's `a`, `sel_en` to its `en`. On a start pulse it steps through a programmable channel range. Each channel is enabled for a programmable dwell time, with optional blanking between channels. It supports single-pass and continuous scanning, and is used for matrix/row scanning in front of the decoder.

## Interface
- DWELL_W, 8, width of dwell count input
- GAP_CYC, 1, blanking cycles with `sel_en` low between channels (legal 0..15)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous and active-low
- start  in  1  scan request, sampled in IDLE only
- stop  in  1  abort request, honoured in any state
- continuous  in  1  0 = single pass, 1 = repeat passes; sampled with `start`
- dwell  in  DWELL_W  enabled cycles per channel; sampled with `start`; value 0 treated as 1
- first_ch  in  4  first channel of range; sampled with `start`
- last_ch  in  4  last channel of range; sampled with `start`
- skip_mask  in  16  bit i = 1 skips channel i; present only with SCAN_SKIP_MASK_EN
- sel  out  4  channel number to decoder
- sel_en  out  1  decoder enable
- busy  out  1  high from the cycle after an accepted `start` until return to IDLE
- ch_done  out  1  one-cycle pulse, last enabled cycle of each channel
- scan_done  out  1  one-cycle pulse, last enabled cycle of each pass

## Operation
- States: IDLE, DWELL, GAP; all outputs registered.
- Reset values (rst_n = 0 at an edge): state IDLE, `sel` 0, `sel_en` 0, `busy` 0, `ch_done` 0, `scan_done` 0. Reset mid-scan aborts with no done pulses.
- IDLE: `sel` = 0, `sel_en` = 0. Transitions on `start` = 1 and `stop` = 0; `stop` wins when both are high. The transition latches `continuous`, `dwell`, `first_ch`, `last_ch` and the mask.
- Range order is `first_ch`, `first_ch`+1, … up to `last_ch`, with 4-bit wrap 15→0. `first_ch` = `last_ch` gives a single-channel pass; `last_ch` < `first_ch` wraps through 15 and 0.
- DWELL: `sel_en` = 1 for exactly `dwell` cycles, using an internal down-counter of DWELL_W bits.
  - In the final cycle `ch_done` = 1.
  - If the channel is the last of the pass, `scan_done` = 1 in the same cycle.
- After the final dwell cycle:
  - Last channel and single pass: go to IDLE; `busy` drops the next cycle; no gap.
  - Otherwise with GAP_CYC > 0: go to GAP.
  - Otherwise with GAP_CYC = 0: go directly to the next channel's DWELL, so `sel` changes while `sel_en` stays high.
- GAP: `sel_en` = 0 and `sel` holds the previous channel for GAP_CYC cycles, then DWELL on the next channel. In continuous mode, the next channel after the last is `first_ch`.
- `stop` in DWELL or GAP: next cycle is IDLE with `sel_en` = 0 and no `ch_done`/`scan_done`. If `stop` coincides with a final dwell cycle, that cycle's pulses still assert (they are already registered) and the next pass does not start.
- `start` while busy is ignored.

## Timing
- `start` sampled at edge N → at N+1: `sel` = `first_ch`, `sel_en` = 1, `busy` = 1.
- Single pass of C channels takes C·dwell + (C−1)·GAP_CYC cycles with `busy` high.
- `stop` sampled at edge N → `sel_en` = 0 and `busy` = 0 at N+1.

## Configuration
- `SCAN_SKIP_MASK_EN` defined: `skip_mask` port exists and is latched with `start`.
  - Masked channels get no dwell, no gap and no `ch_done`; the sequencer jumps to the next unmasked channel in range order.
  - `scan_done` marks the last unmasked channel.
  - If every channel in range is masked: `busy` = 1 for exactly one cycle, `scan_done` pulses in that cycle with `sel_en` = 0, then IDLE, even when `continuous` = 1.
- Not defined: the port is absent and every channel in range is scanned.

## Structure
- Package `scan_seq_pkg`: state enum (IDLE, DWELL, GAP), default constants for DWELL_W and GAP_CYC, channel width constant (4).
- Sub-module `scan_next_ch`: combinational next-channel finder that takes the current channel, `last_ch`, `first_ch` and the mask, and outputs the next channel plus an is_last flag, handling wrap. With the macro off, the mask is tied to 0.

## Test plan
- Reset, then `first_ch`=0, `last_ch`=15, `dwell`=1, GAP_CYC=0, single pass → `sel` 0..15 on consecutive cycles, `sel_en` high for 16 cycles, `scan_done` with `sel`=15, `busy` low at cycle 17.
- `first_ch`=14, `last_ch`=1, `dwell`=3, GAP_CYC=2 → `sel` sequence 14,15,0,1, each with 3 enabled cycles and 2 gap cycles, 18 busy cycles total.
- Continuous, `first_ch`=`last_ch`=5, `dwell`=2 → `scan_done` every 2+GAP_CYC cycles; `stop` mid-dwell → `sel_en`=0 next cycle, no further pulses.
- `start` and `stop` high together in IDLE → `busy` stays 0. `start` pulsed while busy → sequence unchanged.
- rst_n low mid-GAP → next edge all outputs 0; `start` afterwards begins cleanly at `first_ch`.
- With SCAN_SKIP_MASK_EN, mask=16'h00AA, range 0..7 → channels 0,2,4,6 only, `scan_done` at 6. Mask=16'hFFFF → one busy cycle with `scan_done`, `sel_en` never high.

Source files
------------

// File: rtl/scan_seq_pkg.sv
// Shared types and helpers for the decoder channel-scan sequencer.
package scan_seq_pkg;

   localparam int CH_W        = 4;
   localparam int N_CH        = 16;
   localparam int OFF_W       = CH_W + 1;
   localparam int DWELL_W_DEF = 8;
   localparam int GAP_CYC_DEF = 1;

   typedef enum logic [1:0] {
      IDLE,
      DWELL,
      GAP
   } scan_state_t;

   typedef struct packed {
      logic            found;
      logic [CH_W-1:0] ch;
   } ch_hit_t;

   // First unmasked channel at range offset >= from_off, walking first_ch..last_ch with 4-bit wrap.
   function automatic ch_hit_t scan_find(
      input logic [CH_W-1:0]  first_ch,
      input logic [CH_W-1:0]  last_ch,
      input logic [OFF_W-1:0] from_off,
      input logic [N_CH-1:0]  mask
   );
      ch_hit_t         hit;
      logic [CH_W-1:0] span;
      logic [CH_W-1:0] ch;
      hit  = '0;
      span = last_ch - first_ch;
      for (int unsigned k = 0; k < N_CH; k++) begin
         ch = first_ch + CH_W'(k);
         if (!hit.found && OFF_W'(k) >= from_off && OFF_W'(k) <= {1'b0, span} && !mask[ch]) begin
            hit.found = 1'b1;
            hit.ch    = ch;
         end
      end
      return hit;
   endfunction

   // True when no unmasked channel follows ch within the current pass.
   function automatic logic ch_is_last(
      input logic [CH_W-1:0] first_ch,
      input logic [CH_W-1:0] last_ch,
      input logic [CH_W-1:0] ch,
      input logic [N_CH-1:0] mask
   );
      logic [CH_W-1:0] off;
      ch_hit_t         hit;
      off = ch - first_ch;
      hit = scan_find(first_ch, last_ch, {1'b0, off} + OFF_W'(1), mask);
      return !hit.found;
   endfunction

endpackage

// File: rtl/scan_next_ch.sv
// Combinational next-channel finder: next unmasked channel after cur_ch in
// range order, wrapping to the start of the range after the last one.
// is_last flags cur_ch as the final unmasked channel of the pass.
// Without SCAN_SKIP_MASK_EN the parent ties mask to zero.
module scan_next_ch
   import scan_seq_pkg::*;
(
   input  logic [CH_W-1:0] cur_ch,
   input  logic [CH_W-1:0] first_ch,
   input  logic [CH_W-1:0] last_ch,
   input  logic [N_CH-1:0] mask,
   output logic [CH_W-1:0] next_ch,
   output logic            is_last
);

   ch_hit_t         fwd;
   ch_hit_t         wrap;
   logic [CH_W-1:0] off;

   // Search forward within the pass, else restart from the head of the range.
   always_comb begin
      off     = cur_ch - first_ch;
      fwd     = scan_find(first_ch, last_ch, {1'b0, off} + OFF_W'(1), mask);
      wrap    = scan_find(first_ch, last_ch, '0, mask);
      is_last = !fwd.found;
      next_ch = fwd.found ? fwd.ch : (wrap.found ? wrap.ch : first_ch);
   end

endmodule

// File: rtl/decoder_scan_seq.sv
// Channel-scan sequencer driving the sel/en inputs of a 4-to-16 decoder.
// Optional feature macro: SCAN_SKIP_MASK_EN adds the skip_mask port.
module decoder_scan_seq
   import scan_seq_pkg::*;
#(
   parameter int DWELL_W = DWELL_W_DEF,
   parameter int GAP_CYC = GAP_CYC_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               continuous,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [CH_W-1:0]    first_ch,
   input  logic [CH_W-1:0]    last_ch,
`ifdef SCAN_SKIP_MASK_EN
   input  logic [N_CH-1:0]    skip_mask,
`endif
   output logic [CH_W-1:0]    sel,
   output logic               sel_en,
   output logic               busy,
   output logic               ch_done,
   output logic               scan_done
);

   scan_state_t        state;
   logic [DWELL_W-1:0] cnt;
   logic [DWELL_W-1:0] dwell_l;
   logic [DWELL_W-1:0] dwell_eff;
   logic [3:0]         gap_cnt;
   logic               cont_l;
   logic [CH_W-1:0]    first_l;
   logic [CH_W-1:0]    last_l;
   logic [N_CH-1:0]    mask_l;
   logic [N_CH-1:0]    mask_in;
   ch_hit_t            start_hit;
   logic               start_last;
   logic [CH_W-1:0]    nxt_ch;
   logic               cur_last;
   logic               nxt_last;

`ifdef SCAN_SKIP_MASK_EN
   assign mask_in = skip_mask;
`else
   assign mask_in = '0;
`endif

   scan_next_ch u_next (
      .cur_ch   (sel),
      .first_ch (first_l),
      .last_ch  (last_l),
      .mask     (mask_l),
      .next_ch  (nxt_ch),
      .is_last  (cur_last)
   );

   // Start-time lookups on raw inputs, and last-of-pass flag for the channel about to be entered.
   always_comb begin
      dwell_eff  = (dwell == '0) ? DWELL_W'(1) : dwell;
      start_hit  = scan_find(first_ch, last_ch, '0, mask_in);
      start_last = ch_is_last(first_ch, last_ch, start_hit.ch, mask_in);
      nxt_last   = ch_is_last(first_l, last_l, nxt_ch, mask_l);
   end

   // Scan FSM; done pulses are set one edge early so they coincide with the final dwell cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         sel       <= '0;
         sel_en    <= 1'b0;
         busy      <= 1'b0;
         ch_done   <= 1'b0;
         scan_done <= 1'b0;
         cnt       <= '0;
         gap_cnt   <= '0;
         cont_l    <= 1'b0;
         dwell_l   <= DWELL_W'(1);
         first_l   <= '0;
         last_l    <= '0;
         mask_l    <= '0;
      end else begin
         ch_done   <= 1'b0;
         scan_done <= 1'b0;
         case (state)
            IDLE: begin
               sel    <= '0;
               sel_en <= 1'b0;
               busy   <= 1'b0;
               // busy is still high for the single cycle of an all-masked pass, which blocks a restart there.
               if (start && !stop && !busy) begin
                  cont_l  <= continuous;
                  dwell_l <= dwell_eff;
                  first_l <= first_ch;
                  last_l  <= last_ch;
                  mask_l  <= mask_in;
                  busy    <= 1'b1;
                  if (!start_hit.found) begin
                     scan_done <= 1'b1;
                  end else begin
                     state  <= DWELL;
                     sel    <= start_hit.ch;
                     sel_en <= 1'b1;
                     cnt    <= dwell_eff - DWELL_W'(1);
                     if (dwell_eff == DWELL_W'(1)) begin
                        ch_done   <= 1'b1;
                        scan_done <= start_last;
                     end
                  end
               end
            end
            default: begin
               if (stop) begin
                  state  <= IDLE;
                  sel    <= '0;
                  sel_en <= 1'b0;
                  busy   <= 1'b0;
               end else if (state == DWELL && cnt != '0) begin
                  cnt <= cnt - DWELL_W'(1);
                  if (cnt == DWELL_W'(1)) begin
                     ch_done   <= 1'b1;
                     scan_done <= cur_last;
                  end
               end else if (state == DWELL && cur_last && !cont_l) begin
                  state  <= IDLE;
                  sel    <= '0;
                  sel_en <= 1'b0;
                  busy   <= 1'b0;
               end else if (state == DWELL && GAP_CYC > 0) begin
                  state   <= GAP;
                  sel_en  <= 1'b0;
                  gap_cnt <= 4'(GAP_CYC - 1);
               end else if (state == GAP && gap_cnt != '0) begin
                  gap_cnt <= gap_cnt - 4'd1;
               end else begin
                  state  <= DWELL;
                  sel    <= nxt_ch;
                  sel_en <= 1'b1;
                  cnt    <= dwell_l - DWELL_W'(1);
                  if (dwell_l == DWELL_W'(1)) begin
                     ch_done   <= 1'b1;
                     scan_done <= nxt_last;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Bench for decoder_scan_seq: two instances (GAP_CYC 0 and 2) share stimulus,
// each compared per cycle against a timeline model of the scan.
// Honours SCAN_SKIP_MASK_EN when the design is built with it.
module tb_decoder_scan_seq;

   localparam int DW = 8;
`ifdef SCAN_SKIP_MASK_EN
   localparam logic [15:0] MASK_ON = 16'hFFFF;
`else
   localparam logic [15:0] MASK_ON = 16'h0000;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          continuous = 1'b0;
   logic [DW-1:0] dwell = 8'd1;
   logic [3:0]    first_ch = 4'd0;
   logic [3:0]    last_ch = 4'd0;
   logic [15:0]   mask_drv = 16'h0;

   logic [3:0] sel_g0, sel_g2;
   logic       sel_en_g0, sel_en_g2, busy_g0, busy_g2;
   logic       ch_done_g0, ch_done_g2, scan_done_g0, scan_done_g2;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   decoder_scan_seq #(.DWELL_W(DW), .GAP_CYC(0)) dut_g0 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .continuous (continuous),
      .dwell      (dwell),
      .first_ch   (first_ch),
      .last_ch    (last_ch),
`ifdef SCAN_SKIP_MASK_EN
      .skip_mask  (mask_drv),
`endif
      .sel        (sel_g0),
      .sel_en     (sel_en_g0),
      .busy       (busy_g0),
      .ch_done    (ch_done_g0),
      .scan_done  (scan_done_g0)
   );

   decoder_scan_seq #(.DWELL_W(DW), .GAP_CYC(2)) dut_g2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .continuous (continuous),
      .dwell      (dwell),
      .first_ch   (first_ch),
      .last_ch    (last_ch),
`ifdef SCAN_SKIP_MASK_EN
      .skip_mask  (mask_drv),
`endif
      .sel        (sel_g2),
      .sel_en     (sel_en_g2),
      .busy       (busy_g2),
      .ch_done    (ch_done_g2),
      .scan_done  (scan_done_g2)
   );

   always #5 clk = ~clk;

   // Model state per instance: index 0 is GAP_CYC=0, index 1 is GAP_CYC=2.
   bit          m_act  [2];
   int unsigned m_t    [2];
   logic [3:0]  m_first[2];
   logic [3:0]  m_last [2];
   int unsigned m_dw   [2];
   bit          m_cont [2];
   logic [15:0] m_mask [2];

   function automatic int unsigned gap_of(input int d);
      return (d == 0) ? 0 : 2;
   endfunction

   function automatic int unsigned count_n(input int d);
      logic [3:0]  sp;
      logic [3:0]  ch;
      int unsigned n;
      sp = m_last[d] - m_first[d];
      n  = 0;
      for (int k = 0; k <= int'(sp); k++) begin
         ch = m_first[d] + 4'(k);
         if (!m_mask[d][ch]) n++;
      end
      return n;
   endfunction

   function automatic int unsigned pass_len(input int d);
      int unsigned n;
      n = count_n(d);
      if (n == 0) return 1;
      return n * m_dw[d] + (n - 1) * gap_of(d);
   endfunction

   // Expected {sel, sel_en, busy, ch_done, scan_done} at elapsed cycle m_t of the scan.
   function automatic logic [7:0] model_out(input int d);
      logic [3:0]  lst [16];
      logic [3:0]  sp;
      logic [3:0]  ch;
      int unsigned n, per, tt, idx, ph;
      if (!m_act[d]) return 8'h00;
      sp = m_last[d] - m_first[d];
      n  = 0;
      for (int k = 0; k < 16; k++) lst[k] = 4'h0;
      for (int k = 0; k <= int'(sp); k++) begin
         ch = m_first[d] + 4'(k);
         if (!m_mask[d][ch]) begin
            lst[n] = ch;
            n++;
         end
      end
      if (n == 0) return 8'b0000_0101;
      per = m_dw[d] + gap_of(d);
      tt  = m_cont[d] ? (m_t[d] % (n * per)) : m_t[d];
      idx = tt / per;
      ph  = tt % per;
      if (ph < m_dw[d])
         return {lst[idx], 1'b1, 1'b1, (ph == m_dw[d] - 1), (ph == m_dw[d] - 1) && (idx == n - 1)};
      return {lst[idx], 4'b0100};
   endfunction

   task automatic model_edge(input int d);
      if (!rst_n) begin
         m_act[d] = 1'b0;
      end else if (m_act[d]) begin
         if (stop) begin
            m_act[d] = 1'b0;
         end else begin
            m_t[d]++;
            if ((!m_cont[d] || count_n(d) == 0) && m_t[d] >= pass_len(d)) m_act[d] = 1'b0;
         end
      end else if (start && !stop) begin
         m_first[d] = first_ch;
         m_last[d]  = last_ch;
         m_dw[d]    = (dwell == '0) ? 1 : int'(dwell);
         m_cont[d]  = continuous;
         m_mask[d]  = mask_drv & MASK_ON;
         m_act[d]   = 1'b1;
         m_t[d]     = 0;
      end
   endtask

   task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t {sel,en,busy,ch_done,scan_done}: got %b_%b expected %b_%b",
                  tag, $time, act[7:4], act[3:0], exp[7:4], exp[3:0]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      check("gap0", {sel_g0, sel_en_g0, busy_g0, ch_done_g0, scan_done_g0}, model_out(0));
      check("gap2", {sel_g2, sel_en_g2, busy_g2, ch_done_g2, scan_done_g2}, model_out(1));
   endtask

   task automatic start_scan(input logic [3:0] f, input logic [3:0] l, input int unsigned dw,
                             input logic cont, input logic [15:0] mk);
      first_ch   = f;
      last_ch    = l;
      dwell      = DW'(dw);
      continuous = cont;
      mask_drv   = mk;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         m_act[d] = 1'b0; m_t[d] = 0; m_first[d] = '0; m_last[d] = '0;
         m_dw[d] = 1; m_cont[d] = 1'b0; m_mask[d] = '0;
      end

      // Reset
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Full range, dwell 1, single pass
      start_scan(4'd0, 4'd15, 1, 1'b0, 16'h0);
      repeat (40) tick();

      // Wrapping range 14..1, dwell 3
      start_scan(4'd14, 4'd1, 3, 1'b0, 16'h0);
      repeat (25) tick();

      // Continuous single channel, then stop mid-dwell
      start_scan(4'd5, 4'd5, 2, 1'b1, 16'h0);
      repeat (9) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      repeat (5) tick();

      // start and stop together in IDLE
      first_ch = 4'd3; last_ch = 4'd7; dwell = 8'd2;
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      repeat (3) tick();

      // start while busy is ignored; dwell 0 treated as 1
      start_scan(4'd2, 4'd6, 0, 1'b0, 16'h0);
      repeat (2) tick();
      first_ch = 4'd9; last_ch = 4'd9; dwell = 8'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (20) tick();

      // Reset while the gap-2 instance is in its gap, then clean restart
      start_scan(4'd0, 4'd3, 2, 1'b0, 16'h0);
      repeat (2) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      start_scan(4'd4, 4'd6, 1, 1'b0, 16'h0);
      repeat (15) tick();

      // Skip-mask patterns (plain scans when the mask feature is absent)
      start_scan(4'd0, 4'd7, 1, 1'b0, 16'h00AA);
      repeat (25) tick();
      start_scan(4'd0, 4'd7, 2, 1'b1, 16'hFFFF);
      repeat (4) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         rst_n      = ($urandom_range(0, 199) != 0);
         start      = ($urandom_range(0, 5) == 0);
         stop       = ($urandom_range(0, 39) == 0);
         continuous = ($urandom_range(0, 3) == 0);
         dwell      = DW'($urandom_range(0, 4));
         first_ch   = 4'($urandom);
         last_ch    = 4'($urandom);
         case ($urandom_range(0, 3))
            0:       mask_drv = 16'h0000;
            1:       mask_drv = 16'hFFFF;
            default: mask_drv = 16'($urandom);
         endcase
         tick();
      end

      rst_n = 1'b1; start = 1'b0; stop = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
